// File: rtl/truth_table_sweep_checker_if.sv
// Sweep/compare bus between the truth-table sweep checker and the function pair under test.
// The checker drives vec_out and the result signals; the environment drives start and both function outputs.
interface truth_table_sweep_checker_if #(
  parameter int NVARS = 4
);
  logic                  start;
  logic [NVARS-1:0]      vec_out;
  logic                  com_in;
  logic                  sim_in;
  logic                  busy;
  logic                  done;
  logic [NVARS:0]        mismatch_cnt;
  logic [2**NVARS-1:0]   mismatch_mask;
  logic                  equiv;

  modport master (
    output start, com_in, sim_in,
    input  vec_out, busy, done, mismatch_cnt, mismatch_mask, equiv
  );

  modport slave (
    input  start, com_in, sim_in,
    output vec_out, busy, done, mismatch_cnt, mismatch_mask, equiv
  );
endinterface

// File: rtl/truth_table_sweep_checker.sv
// Clocked sweep-and-compare engine: walks all 2**NVARS input vectors, compares two function outputs.
// Optional macro EARLY_STOP_EN ends the sweep at the first mismatching vector.
module truth_table_sweep_checker #(
  parameter int NVARS  = 4,
  parameter int SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  truth_table_sweep_checker_if.slave   bus
);

  localparam int CW = NVARS + 1;
  localparam int NV = 2**NVARS;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NVARS-1:0]  r_vec;
  logic [3:0]        r_settle;
  logic [CW-1:0]     r_cnt;
  logic [NV-1:0]     r_mask;
  logic              r_busy;
  logic              r_done;
  logic              r_equiv;

  logic              w_accept;
  logic              w_sample;
  logic              w_end;
  logic              w_settled;
  logic              w_last;
  logic              w_miss;
  logic [CW-1:0]     w_cnt_nxt;

  assign w_settled = (r_settle == 4'(SETTLE));
  assign w_last    = (r_vec == {NVARS{1'b1}});
  assign w_miss    = bus.com_in ^ bus.sim_in;
  assign w_cnt_nxt = r_cnt + CW'(w_miss);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (w_settled) begin
          w_sample = 1'b1;
`ifdef EARLY_STOP_EN
          w_end    = w_last | w_miss;
`else
          w_end    = w_last;
`endif
          if (w_end) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sampling happens on the last edge of each vector's hold window; vec_out
  // freezes on the final (or first failing) vector so results stay readable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_settle <= '0;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_equiv  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_vec    <= '0;
        r_settle <= '0;
        r_cnt    <= '0;
        r_mask   <= '0;
        r_equiv  <= 1'b0;
        r_busy   <= 1'b1;
      end else if (w_sample) begin
        r_settle <= '0;
        if (w_miss) begin
          r_mask[r_vec] <= 1'b1;
          r_cnt         <= w_cnt_nxt;
        end
        if (w_end) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_equiv <= (w_cnt_nxt == '0);
        end else begin
          r_vec <= r_vec + NVARS'(1);
        end
      end else if (r_state == DRIVE) begin
        r_settle <= r_settle + 4'd1;
      end
    end
  end

  assign bus.vec_out       = r_vec;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.mismatch_cnt  = r_cnt;
  assign bus.mismatch_mask = r_mask;
  assign bus.equiv         = r_equiv;

endmodule

// File: tb/tb_truth_table_sweep_checker.sv
// Directed testbench for truth_table_sweep_checker: NVARS=4/SETTLE=1 and NVARS=2/SETTLE=0 instances.
module tb_truth_table_sweep_checker;

`ifdef EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mode = 0;

  always #5 clk = ~clk;

  truth_table_sweep_checker_if #(.NVARS(4)) ifa ();
  truth_table_sweep_checker_if #(.NVARS(2)) ifb ();

  truth_table_sweep_checker #(.NVARS(4), .SETTLE(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  truth_table_sweep_checker #(.NVARS(2), .SETTLE(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  // Function pairs under test; vec_out bits are {x, y, w, z}.
  logic ax, ay, aw, az, acom;
  always_comb begin
    {ax, ay, aw, az} = ifa.vec_out;
    acom       = ax & ~(ay & aw & az);
    ifa.com_in = 1'b0;
    ifa.sim_in = 1'b0;
    case (mode)
      0: begin
        ifa.com_in = acom;
        ifa.sim_in = (ax & ~aw) | (ax & ~ay & aw) | (ax & aw & ~az);
      end
      1: begin
        ifa.com_in = acom;
        ifa.sim_in = acom ^ (ifa.vec_out == 4'd5);
      end
      2: begin
        ifa.com_in = ax;
        ifa.sim_in = 1'b0;
      end
      default: begin
        ifa.com_in = 1'b1;
        ifa.sim_in = 1'b0;
      end
    endcase
    ifb.com_in = ifb.vec_out[0];
    ifb.sim_in = ifb.vec_out[0];
  end

  // Starts a sweep on instance A and returns the number of edges after E0 until done is seen.
  task automatic run_sweep_a(input int m, input int restart_at, output int lat);
    mode = m;
    @(negedge clk); ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk); ifa.start = 1'b0;
    lat = 0;
    while (!ifa.done && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      ifa.start = (lat == restart_at);
    end
    ifa.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ifa.start = 1'b0; ifb.start = 1'b0; mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (ifa.vec_out !== 4'd0) begin n_fail++; $display("FAIL reset_vec: got %0d want 0", ifa.vec_out); end
    n_chk++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", ifa.busy); end
    n_chk++; if (ifa.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", ifa.done); end
    n_chk++; if (ifa.mismatch_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", ifa.mismatch_cnt); end
    n_chk++; if (ifa.mismatch_mask !== 16'h0000) begin n_fail++; $display("FAIL reset_mask: got %h want 0000", ifa.mismatch_mask); end
    n_chk++; if (ifa.equiv !== 1'b0) begin n_fail++; $display("FAIL reset_equiv: got %0b want 0", ifa.equiv); end
    n_chk++; if (ifb.busy !== 1'b0 || ifb.vec_out !== 2'd0) begin n_fail++; $display("FAIL reset_b: busy %0b vec %0d want 0 0", ifb.busy, ifb.vec_out); end
    // Reset and start together: reset wins.
    ifa.start = 1'b1;
    @(posedge clk); @(negedge clk);
    n_chk++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_vs_start: busy %0b want 0", ifa.busy); end
    ifa.start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %0b want 0", ifa.busy); end
  endtask

  task automatic test_equivalent();
    int lat;
    run_sweep_a(0, -1, lat);
    n_chk++; if (lat !== 32) begin n_fail++; $display("FAIL equiv_latency: got %0d want 32", lat); end
    n_chk++; if (ifa.equiv !== 1'b1) begin n_fail++; $display("FAIL equiv_equiv: got %0b want 1", ifa.equiv); end
    n_chk++; if (ifa.mismatch_cnt !== 5'd0) begin n_fail++; $display("FAIL equiv_cnt: got %0d want 0", ifa.mismatch_cnt); end
    n_chk++; if (ifa.mismatch_mask !== 16'h0000) begin n_fail++; $display("FAIL equiv_mask: got %h want 0000", ifa.mismatch_mask); end
    n_chk++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL equiv_busy: got %0b want 0", ifa.busy); end
    n_chk++; if (ifa.vec_out !== 4'd15) begin n_fail++; $display("FAIL equiv_vec: got %0d want 15", ifa.vec_out); end
    @(negedge clk);
    n_chk++; if (ifa.done !== 1'b0) begin n_fail++; $display("FAIL equiv_done_pulse: got %0b want 0", ifa.done); end
    n_chk++; if (ifa.equiv !== 1'b1) begin n_fail++; $display("FAIL equiv_hold: got %0b want 1", ifa.equiv); end
  endtask

  task automatic test_fault();
    int lat;
    run_sweep_a(1, -1, lat);
    n_chk++; if (lat !== (EARLY ? 12 : 32)) begin n_fail++; $display("FAIL fault_latency: got %0d want %0d", lat, EARLY ? 12 : 32); end
    n_chk++; if (ifa.mismatch_cnt !== 5'd1) begin n_fail++; $display("FAIL fault_cnt: got %0d want 1", ifa.mismatch_cnt); end
    n_chk++; if (ifa.mismatch_mask !== 16'h0020) begin n_fail++; $display("FAIL fault_mask: got %h want 0020", ifa.mismatch_mask); end
    n_chk++; if (ifa.equiv !== 1'b0) begin n_fail++; $display("FAIL fault_equiv: got %0b want 0", ifa.equiv); end
    n_chk++; if (ifa.vec_out !== (EARLY ? 4'd5 : 4'd15)) begin n_fail++; $display("FAIL fault_vec: got %0d want %0d", ifa.vec_out, EARLY ? 5 : 15); end
    @(negedge clk);
  endtask

  task automatic test_half();
    int lat;
    run_sweep_a(2, -1, lat);
    n_chk++; if (lat !== (EARLY ? 18 : 32)) begin n_fail++; $display("FAIL half_latency: got %0d want %0d", lat, EARLY ? 18 : 32); end
    n_chk++; if (ifa.mismatch_cnt !== (EARLY ? 5'd1 : 5'd8)) begin n_fail++; $display("FAIL half_cnt: got %0d want %0d", ifa.mismatch_cnt, EARLY ? 1 : 8); end
    n_chk++; if (ifa.mismatch_mask !== (EARLY ? 16'h0100 : 16'hFF00)) begin n_fail++; $display("FAIL half_mask: got %h want %h", ifa.mismatch_mask, EARLY ? 16'h0100 : 16'hFF00); end
    n_chk++; if (ifa.equiv !== 1'b0) begin n_fail++; $display("FAIL half_equiv: got %0b want 0", ifa.equiv); end
    n_chk++; if (ifa.vec_out !== (EARLY ? 4'd8 : 4'd15)) begin n_fail++; $display("FAIL half_vec: got %0d want %0d", ifa.vec_out, EARLY ? 8 : 15); end
    @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    int lat;
    run_sweep_a(1, 10, lat);
    n_chk++; if (lat !== (EARLY ? 12 : 32)) begin n_fail++; $display("FAIL restart_latency: got %0d want %0d", lat, EARLY ? 12 : 32); end
    n_chk++; if (ifa.mismatch_cnt !== 5'd1) begin n_fail++; $display("FAIL restart_cnt: got %0d want 1", ifa.mismatch_cnt); end
    n_chk++; if (ifa.mismatch_mask !== 16'h0020) begin n_fail++; $display("FAIL restart_mask: got %h want 0020", ifa.mismatch_mask); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    run_sweep_a(2, -1, lat);
    // start held through DONE is ignored there, then accepted once IDLE.
    ifa.start = 1'b1;
    @(posedge clk); @(negedge clk);
    n_chk++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_start: busy %0b want 0", ifa.busy); end
    n_chk++; if (ifa.mismatch_cnt !== (EARLY ? 5'd1 : 5'd8)) begin n_fail++; $display("FAIL b2b_hold_cnt: got %0d want %0d", ifa.mismatch_cnt, EARLY ? 1 : 8); end
    @(posedge clk); @(negedge clk);
    ifa.start = 1'b0;
    n_chk++; if (ifa.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy %0b want 1", ifa.busy); end
    n_chk++; if (ifa.mismatch_cnt !== 5'd0) begin n_fail++; $display("FAIL b2b_clear: cnt %0d want 0", ifa.mismatch_cnt); end
    lat = 0;
    while (!ifa.done && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    n_chk++; if (lat !== (EARLY ? 18 : 32)) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, EARLY ? 18 : 32); end
    n_chk++; if (ifa.mismatch_cnt !== (EARLY ? 5'd1 : 5'd8)) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", ifa.mismatch_cnt, EARLY ? 1 : 8); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep();
    int  lat;
    bit  saw_done;
    mode = 3;
    @(negedge clk); ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk); ifa.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_chk++; if (ifa.mismatch_cnt !== (EARLY ? 5'd1 : 5'd5)) begin n_fail++; $display("FAIL mid_cnt: got %0d want %0d", ifa.mismatch_cnt, EARLY ? 1 : 5); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    n_chk++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.equiv !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctl: busy %0b done %0b equiv %0b want 0 0 0", ifa.busy, ifa.done, ifa.equiv); end
    n_chk++; if (ifa.mismatch_cnt !== 5'd0 || ifa.mismatch_mask !== 16'h0000 || ifa.vec_out !== 4'd0) begin n_fail++; $display("FAIL mid_reset_data: cnt %0d mask %h vec %0d want 0 0000 0", ifa.mismatch_cnt, ifa.mismatch_mask, ifa.vec_out); end
    saw_done = 1'b0;
    for (lat = 0; lat < 40; lat++) begin
      @(negedge clk);
      if (ifa.done || ifa.busy) saw_done = 1'b1;
    end
    n_chk++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: activity %0b want 0", saw_done); end
  endtask

  task automatic test_nvars2_settle0();
    int lat;
    @(negedge clk); ifb.start = 1'b1;
    @(posedge clk);
    @(negedge clk); ifb.start = 1'b0;
    lat = 0;
    while (!ifb.done && lat < 50) begin
      if (lat < 4) begin
        n_chk++; if (ifb.vec_out !== 2'(lat)) begin n_fail++; $display("FAIL n2_step%0d: vec %0d want %0d", lat, ifb.vec_out, lat); end
      end
      @(posedge clk); lat++; @(negedge clk);
    end
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL n2_latency: got %0d want 4", lat); end
    n_chk++; if (ifb.equiv !== 1'b1) begin n_fail++; $display("FAIL n2_equiv: got %0b want 1", ifb.equiv); end
    n_chk++; if (ifb.mismatch_cnt !== 3'd0 || ifb.mismatch_mask !== 4'h0) begin n_fail++; $display("FAIL n2_results: cnt %0d mask %h want 0 0", ifb.mismatch_cnt, ifb.mismatch_mask); end
    n_chk++; if (ifb.vec_out !== 2'd3) begin n_fail++; $display("FAIL n2_vec_hold: got %0d want 3", ifb.vec_out); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_equivalent();
    test_fault();
    test_half();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_sweep();
    test_nvars2_settle0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
